// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if -- signal bundle between a UART receiver and its environment.
//
// Build option: UART_RX_PARITY_EN adds the parity_err pulse.
//
// Signals:
//   rx          serial line into the receiver, idle high
//   rx_data     last correctly framed byte
//   donerx      one-clock pulse, rx_data just updated
//   frame_err   one-clock pulse, stop bit was sampled low
//   parity_err  one-clock pulse with donerx on even-parity mismatch (option)
//   dbg_state   current receiver FSM state, for observation only
//
// Handshake: there is no back-pressure. donerx and frame_err are single-cycle
// strobes; a consumer must capture rx_data in the cycle donerx is high or
// any later cycle before the next donerx. The two strobes are never high
// together, and parity_err only ever accompanies donerx.
//
// Modports: master = line driver / consumer, slave = the receiver.
// ----------------------------------------------------------------------------
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       donerx;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif
    logic [2:0] dbg_state;

`ifdef UART_RX_PARITY_EN
    modport master (output rx, input rx_data, input donerx, input frame_err,
                    input parity_err, input dbg_state);
    modport slave  (input rx, output rx_data, output donerx, output frame_err,
                    output parity_err, output dbg_state);
`else
    modport master (output rx, input rx_data, input donerx, input frame_err,
                    input dbg_state);
    modport slave  (input rx, output rx_data, output donerx, output frame_err,
                    output dbg_state);
`endif
endinterface

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with mid-bit sampling.
//
// Build option: UART_RX_PARITY_EN inserts an even-parity bit between the data
// bits and the stop bit and drives bus.parity_err.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   uart_rx_if.slave: rx in; rx_data, donerx, frame_err,
//         [parity_err], dbg_state out
//
// Timing, with t0 the clock at which the synchronized line is first seen
// low after being high: start bit re-checked at t0+HALF, data bit i at
// t0+HALF+(i+1)*CLKS_PER_BIT, then (parity and) stop one bit period apart.
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);
    localparam int CLKS_PER_BIT = clk_freq / baud_rate;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(HALF - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [1:0]    r_sync;
    logic          r_rs_prev;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_rx_data;
    logic          r_donerx;
    logic          r_frame_err;
`ifdef UART_RX_PARITY_EN
    logic          r_par_bit;
    logic          r_parity_err;
`endif
    logic          w_rs;

    assign w_rs = r_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchronizer and edge history reset to the idle level so that
            // leaving reset never looks like a start edge.
            r_sync       <= 2'b11;
            r_rs_prev    <= 1'b1;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_rx_data    <= '0;
            r_donerx     <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_sync      <= {r_sync[0], bus.rx};
            r_rs_prev   <= w_rs;
            r_donerx    <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    // Only a fresh 1->0 edge starts a frame; a line held low
                    // after a bad stop bit does not retrigger.
                    if (!w_rs && r_rs_prev) begin
                        r_bit_idx <= '0;
                        r_cnt     <= HALF_RELOAD;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == '0) begin
                        if (!w_rs) begin
                            r_cnt   <= BIT_RELOAD;
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;   // glitch, not a start bit
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == '0) begin
                        r_shift[r_bit_idx] <= w_rs;
                        r_cnt              <= BIT_RELOAD;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_cnt == '0) begin
                        r_par_bit <= w_rs;
                        r_cnt     <= BIT_RELOAD;
                        r_state   <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (r_cnt == '0) begin
                        if (w_rs) begin
                            r_rx_data <= r_shift;
                            r_donerx  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            // Even parity: data plus parity bit XOR to zero.
                            r_parity_err <= (^r_shift) ^ r_par_bit;
`endif
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_data    = r_rx_data;
    assign bus.donerx     = r_donerx;
    assign bus.frame_err  = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = r_parity_err;
`endif
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 9600;
    localparam int CPB      = CLK_FREQ / BAUD;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_if bus ();

    uart_rx #(.clk_freq(CLK_FREQ), .baud_rate(BAUD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- monitor (records events, sampled on negedge) --------
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int done_cnt = 0, ferr_cnt = 0, both_cnt = 0;
    int done_run = 0, ferr_run = 0, max_done_run = 0, max_ferr_run = 0;
    int pe_cnt = 0, pe_orphan = 0;

    always @(negedge clk) begin
        if (bus.donerx === 1'b1) begin
            done_cnt++;
            got_q.push_back(bus.rx_data);
            done_run++;
            if (done_run > max_done_run) max_done_run = done_run;
        end else begin
            done_run = 0;
        end
        if (bus.frame_err === 1'b1) begin
            ferr_cnt++;
            ferr_run++;
            if (ferr_run > max_ferr_run) max_ferr_run = ferr_run;
        end else begin
            ferr_run = 0;
        end
        if (bus.donerx === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
`ifdef UART_RX_PARITY_EN
        if (bus.parity_err === 1'b1) begin
            pe_cnt++;
            if (bus.donerx !== 1'b1) pe_orphan++;
        end
`endif
    end

    // ---------------- reference model state ----------------
    logic [7:0] model_last;
    int d0, f0, p0;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v, input int n);
        bus.rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input logic par);
        send_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) send_bit(data[i], CPB);
`ifdef UART_RX_PARITY_EN
        send_bit(par, CPB);
`endif
        send_bit(stop, CPB);
    endtask

    task automatic snap();
        d0 = done_cnt;
        f0 = ferr_cnt;
        p0 = pe_cnt;
    endtask

    // Model of one frame: good stop -> byte delivered, parity flagged on odd
    // total ones; bad stop -> frame error only, last byte kept.
    task automatic model_frame(input logic [7:0] data, input logic stop, input logic par,
                               output int e_done, output int e_ferr, output int e_pe);
        e_done = stop ? 1 : 0;
        e_ferr = stop ? 0 : 1;
        e_pe   = 0;
        if (stop) begin
            exp_q.push_back(data);
            model_last = data;
            e_pe = ((^data) ^ par) ? 1 : 0;
        end
    endtask

    task automatic check_bytes(input string tag);
        logic [7:0] e, g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() > 0) g = got_q.pop_front();
            else g = 8'hxx;
            check(tag, {24'd0, g}, {24'd0, e});
        end
        check({tag, "_extra"}, got_q.size(), 0);
        got_q.delete();
    endtask

    task automatic frame_step(input string tag, input logic [7:0] data,
                              input logic stop, input logic par);
        int e_done, e_ferr, e_pe;
        snap();
        model_frame(data, stop, par, e_done, e_ferr, e_pe);
        send_frame(data, stop, par);
        send_bit(1'b1, stop ? 8 : 2 * CPB);
        check({tag, "_done"}, done_cnt - d0, e_done);
        check({tag, "_ferr"}, ferr_cnt - f0, e_ferr);
        check_bytes({tag, "_byte"});
        check({tag, "_rxdata"}, {24'd0, bus.rx_data}, {24'd0, model_last});
`ifdef UART_RX_PARITY_EN
        check({tag, "_perr"}, pe_cnt - p0, e_pe);
`endif
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [7:0] rd;
        logic       rs, rp;
        int e_done, e_ferr, e_pe;

        bus.rx = 1'b1;
        model_last = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rxdata", {24'd0, bus.rx_data}, 32'h0);
        check("reset_done",   {31'd0, bus.donerx}, 32'h0);
        check("reset_ferr",   {31'd0, bus.frame_err}, 32'h0);
        check("reset_state",  {29'd0, bus.dbg_state}, 32'h0);
        rst = 1'b0;
        send_bit(1'b1, 20);

        // Basic frame.
        frame_step("f55", 8'h55, 1'b1, 1'b0);

        // Short low glitch is rejected at the start-bit re-check.
        snap();
        send_bit(1'b0, 20);
        send_bit(1'b1, 2 * CPB);
        check("glitch_done",  done_cnt - d0, 0);
        check("glitch_ferr",  ferr_cnt - f0, 0);
        check("glitch_state", {29'd0, bus.dbg_state}, 32'h0);
        frame_step("f3c", 8'h3C, 1'b1, 1'b0);

        // Bad stop bit.
        frame_step("a3_badstop", 8'hA3, 1'b0, 1'b0);

        // Reset in the middle of data bit 3; line released at the same time.
        snap();
        send_bit(1'b0, CPB);
        send_bit(1'b1, CPB);               // bit0 of 0x81
        send_bit(1'b0, CPB);               // bit1
        send_bit(1'b0, CPB);               // bit2
        send_bit(1'b0, CPB / 2);           // half of bit3
        rst = 1'b1;
        bus.rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_last = 8'h00;
        send_bit(1'b1, 12 * CPB);
        check("rstmid_done",   done_cnt - d0, 0);
        check("rstmid_ferr",   ferr_cnt - f0, 0);
        check("rstmid_rxdata", {24'd0, bus.rx_data}, 32'h0);
        frame_step("f0f", 8'h0F, 1'b1, 1'b0);

        // Back-to-back frames with a single stop bit.
        snap();
        model_frame(8'h00, 1'b1, 1'b0, e_done, e_ferr, e_pe);
        model_frame(8'hFF, 1'b1, 1'b0, e_done, e_ferr, e_pe);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_bit(1'b1, 8);
        check("b2b_done", done_cnt - d0, 2);
        check("b2b_ferr", ferr_cnt - f0, 0);
        check_bytes("b2b_byte");

        // Break: bad stop then line held low -> one frame error, no retrigger.
        snap();
        send_frame(8'h00, 1'b0, 1'b0);
        send_bit(1'b0, 20 * CPB);
        send_bit(1'b1, 2 * CPB);
        check("break_ferr", ferr_cnt - f0, 1);
        check("break_done", done_cnt - d0, 0);
        check("break_rxdata", {24'd0, bus.rx_data}, {24'd0, model_last});

`ifdef UART_RX_PARITY_EN
        frame_step("par07_p0", 8'h07, 1'b1, 1'b0);
        frame_step("par07_p1", 8'h07, 1'b1, 1'b1);
`endif

        // Randomized frames, mostly good stop bits.
        for (int k = 0; k < 10; k++) begin
            rd = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            rp = 1'($urandom_range(0, 1));
            frame_step("rand", rd, rs, rp);
        end

        // Global properties over the whole run.
        check("pulse_width_done", max_done_run, 1);
        check("pulse_width_ferr", max_ferr_run, 1);
        check("done_and_ferr",    both_cnt, 0);
`ifdef UART_RX_PARITY_EN
        check("perr_without_done", pe_orphan, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter clk_freq, default 1000000, system clock frequency in Hz.
REQ-002 SHALL have parameter baud_rate, default 9600, line bit rate; CLKS_PER_BIT = clk_freq/baud_rate (integer division, 104 at defaults), HALF = CLKS_PER_BIT/2 (52).
REQ-003 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data  output  8  last correctly framed byte, LSB received first.
REQ-007 SHALL have port donerx  output  1  one-clk pulse: rx_data updated.
REQ-008 SHALL have port frame_err  output  1  one-clk pulse: stop bit sampled 0.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer; all decisions use synchronized value rs; latency rx->rs is 2 clk.
REQ-010 SHALL implement states IDLE, START, DATA, STOP (plus PARITY, see Configuration).
REQ-011 IDLE: on cycle t0 where rs=0 and previous rs=1 (falling edge), SHALL clear bit counter, load baud counter, enter START.
REQ-012 START: SHALL resample rs at t0+HALF; rs=0 -> DATA; rs=1 -> IDLE (glitch rejected, no output pulse).
REQ-013 DATA: SHALL sample bit i (i=0..7) at t0+HALF+(i+1)*CLKS_PER_BIT into shift register position i; after bit 7 -> STOP.
REQ-014 STOP: SHALL sample rs at t0+HALF+9*CLKS_PER_BIT.
REQ-015 Stop=1: next cycle rx_data <= shift register and donerx=1 for exactly one clk; frame_err stays 0.
REQ-016 Stop=0: next cycle frame_err=1 for exactly one clk; rx_data unchanged; donerx stays 0.
REQ-017 After STOP SHALL return to IDLE; a new start is accepted only on a fresh rs 1->0 edge (held-low break produces a single frame_err, no retrigger).
REQ-018 Back-to-back frames (next start bit immediately after a 1-bit stop) SHALL be received without loss.
REQ-019 donerx and frame_err SHALL never be asserted in the same cycle.
REQ-020 Baud counter SHALL be sized for CLKS_PER_BIT-1; no wrap-around within a bit period.

Reset
REQ-021 While rst=1 at a clk edge: state=IDLE, rx_data=8'h00, donerx=0, frame_err=0, parity_err=0, counters=0, synchronizer flops=1.
REQ-022 Reset mid-frame SHALL abandon the frame with no output pulse; reception resumes on the first falling edge after rst deasserts.

Configuration
REQ-023 Macro UART_RX_PARITY_EN SHALL, when defined, add output parity_err (1 bit) and state PARITY between DATA and STOP.
REQ-024 With UART_RX_PARITY_EN: parity bit sampled at t0+HALF+9*CLKS_PER_BIT, stop at t0+HALF+10*CLKS_PER_BIT; even parity expected (XOR of 8 data bits and parity bit = 0).
REQ-025 With UART_RX_PARITY_EN and valid stop: rx_data and donerx behave per REQ-015; parity_err pulses one clk in the same cycle as donerx if parity mismatches; parity_err never asserted with frame_err.
REQ-026 Without UART_RX_PARITY_EN: no parity_err port, no PARITY state, 10-bit frame timing per REQ-013/014.

Verification (defaults, 104 clk/bit)
REQ-027 Frame 0x55, stop=1 -> rx_data=8'h55, donerx high exactly 1 clk, frame_err=0.
REQ-028 rx low for 20 clk then high -> no donerx, no frame_err, state back to IDLE; following 0x3C frame received as 8'h3C.
REQ-029 After 0x55, frame 0xA3 with stop=0 -> frame_err 1-clk pulse, rx_data stays 8'h55, donerx=0.
REQ-030 rst pulsed 1 clk during data bit 3 of 0x81 -> no pulses, rx_data=8'h00; next frame 0x0F -> rx_data=8'h0F, donerx pulse.
REQ-031 Frames 0x00 then 0xFF back-to-back, single stop bit -> two donerx pulses, rx_data 8'h00 then 8'hFF.
REQ-032 UART_RX_PARITY_EN defined: 0x07 with parity bit 0 -> rx_data=8'h07, donerx and parity_err pulse same clk; with parity bit 1 -> parity_err=0.
